// File: rtl/mem_responder_pkg.sv
// Shared CPU definitions: memory-responder FSM encoding and timing constants.
// Imported by the responder and any pipeline logic that inspects its state.
package mem_responder_pkg;

  localparam int CNT_W           = 4;
  localparam int DEFAULT_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage: synchronous write, registered read, no reset; one access per cycle.
// Latency 1 cycle for reads; never stalls.
module mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem[addr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the MEM stage: accept, wait LATENCY cycles, ack.
// Holds stall_o while a request is pending; a new request may be accepted on the ack cycle.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             ack_o,
  output logic             stall_o,
  output logic             err_o
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [WIDTH:0] lim_t;
  localparam lim_t             ADDR_LIMIT = lim_t'(4 * DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic             accept;
  logic             access;
  logic             addr_err;
  logic             mem_we;
  logic             mem_re;
  logic [WIDTH-1:0] rdata;

  // Checked on the captured address only, so live inputs never affect the outcome.
  assign addr_err = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= ADDR_LIMIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    access  = 1'b0;
    stall_o = 1'b0;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_i) begin
          stall_o = 1'b1;
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt_q == '0) begin
          access  = 1'b1;
          err_d   = addr_err;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (cs_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      we_d   = we_i;
      addr_d = addr_i;
      data_d = data_i;
      cnt_d  = CNT_LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign mem_we = access && we_q && !addr_err;
  assign mem_re = access && !we_q && !addr_err;

  mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (data_q),
    .rdata_o (rdata)
  );

  // Outputs are derived from state so an asynchronous reset clears them at once.
  assign ack_o  = (state_q == RESP);
  assign err_o  = ack_o && err_q;
  assign data_o = (ack_o && !we_q && !err_q) ? rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: scoreboard of expected completions (data, err, ack cycle)
// filled when requests are issued, drained as acks appear; LATENCY=3 and LATENCY=1 instances.
module tb_mem_responder;

  localparam int W = 32;
  localparam int D = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         cs, we;
  logic [W-1:0] addr, wdat;
  logic [W-1:0] data_o;
  logic         ack_o, stall_o, err_o;

  logic         cs1, we1;
  logic [W-1:0] addr1, wdat1;
  logic [W-1:0] data1_o;
  logic         ack1_o, stall1_o, err1_o;

  mem_responder #(.WIDTH(W), .DEPTH(D), .LATENCY(3)) u_dut (
    .clk(clk), .rst(rst), .cs_i(cs), .we_i(we), .addr_i(addr), .data_i(wdat),
    .data_o(data_o), .ack_o(ack_o), .stall_o(stall_o), .err_o(err_o)
  );

  mem_responder #(.WIDTH(W), .DEPTH(D), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .cs_i(cs1), .we_i(we1), .addr_i(addr1), .data_i(wdat1),
    .data_o(data1_o), .ack_o(ack1_o), .stall_o(stall1_o), .err_o(err1_o)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] sb1[$];
  logic [W-1:0] model [D];
  logic         rq_we[$];
  logic [W-1:0] rq_addr[$];
  logic [W-1:0] rq_dat[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic rq_clear();
    rq_we.delete(); rq_addr.delete(); rq_dat.delete();
  endtask

  task automatic rq_add(input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
    rq_we.push_back(w); rq_addr.push_back(a); rq_dat.push_back(d);
  endtask

  task automatic present(input int k);
    cs = 1'b1; we = rq_we[k]; addr = rq_addr[k]; wdat = rq_dat[k];
  endtask

  task automatic scramble();
    we   = ($urandom_range(0, 1) != 0);
    addr = $urandom & 32'h0000_007C;
    wdat = $urandom;
  endtask

  // Called at a falling edge with the DUT idle; request k is accepted 4*k+1 edges later.
  task automatic start_seq();
    int           base;
    logic         e;
    logic [W-1:0] a;
    exp_t         x;
    base = cyc + 1;
    for (int k = 0; k < rq_we.size(); k++) begin
      a = rq_addr[k];
      e = (a[1:0] != 2'b00) || (a >= 4 * D);
      x.err  = e;
      x.cyc  = base + 4 * k + 3;
      x.data = (!e && !rq_we[k]) ? model[int'(a[6:2])] : '0;
      if (!e && rq_we[k]) model[int'(a[6:2])] = rq_dat[k];
      sb.push_back(x);
    end
    present(0);
  endtask

  task automatic test_reset();
    cs = 0; we = 0; addr = 0; wdat = 0;
    cs1 = 0; we1 = 0; addr1 = 0; wdat1 = 0;
    rst = 0;
    #2 rst = 1;
    #1;
    checks++; if (ack_o !== 1'b0)   begin errors++; $display("FAIL rst_ack got %b exp 0", ack_o); end
    checks++; if (err_o !== 1'b0)   begin errors++; $display("FAIL rst_err got %b exp 0", err_o); end
    checks++; if (data_o !== '0)    begin errors++; $display("FAIL rst_data got %h exp 0", data_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall_idle got %b exp 0", stall_o); end
    checks++; if (ack1_o !== 1'b0)  begin errors++; $display("FAIL rst_ack1 got %b exp 0", ack1_o); end
    cs = 1; #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rst_stall_cs got %b exp 1", stall_o); end
    cs = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++; if (ack_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++; $display("FAIL rst_release ack %b stall %b exp 0 0", ack_o, stall_o);
    end
  endtask

  task automatic test_write_read();
    int   acks = 0;
    exp_t e;
    logic exp_stall;
    rq_clear();
    rq_add(1'b1, 32'h08, 32'hDEAD_BEEF);
    rq_add(1'b0, 32'h08, 32'h0);
    start_seq();
    for (int i = 0; i < 40 && acks < 2; i++) begin
      @(negedge clk);
      exp_stall = !(sb.size() != 0 && sb[0].cyc == cyc);
      checks++; if (stall_o !== exp_stall) begin errors++; $display("FAIL wr_rd_stall cyc %0d got %b exp %b", cyc, stall_o, exp_stall); end
      if (ack_o) begin
        e = sb.pop_front(); acks++;
        checks++; if (cyc !== e.cyc)     begin errors++; $display("FAIL wr_rd_ack_cyc got %0d exp %0d", cyc, e.cyc); end
        checks++; if (data_o !== e.data) begin errors++; $display("FAIL wr_rd_data got %h exp %h", data_o, e.data); end
        checks++; if (err_o !== e.err)   begin errors++; $display("FAIL wr_rd_err got %b exp %b", err_o, e.err); end
        if (acks < 2) present(acks); else cs = 0;
      end else scramble();
    end
    checks++; if (acks != 2) begin errors++; $display("FAIL wr_rd_timeout acks %0d exp 2", acks); sb.delete(); end
    cs = 0;
    @(negedge clk);
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL wr_rd_ack_width got %b exp 0", ack_o); end
  endtask

  task automatic test_back_to_back();
    int   acks = 0;
    int   n;
    exp_t e;
    logic exp_stall;
    rq_clear();
    rq_add(1'b1, 32'h00, 32'hA0A0_A0A0);
    rq_add(1'b1, 32'h04, 32'hB1B1_B1B1);
    rq_add(1'b1, 32'h10, 32'hCAFE_0001);
    rq_add(1'b0, 32'h00, 32'h0);
    rq_add(1'b0, 32'h04, 32'h0);
    rq_add(1'b0, 32'h08, 32'h0);
    n = rq_we.size();
    start_seq();
    for (int i = 0; i < 20 * n && acks < n; i++) begin
      @(negedge clk);
      exp_stall = !(sb.size() != 0 && sb[0].cyc == cyc);
      checks++; if (stall_o !== exp_stall) begin errors++; $display("FAIL b2b_stall cyc %0d got %b exp %b", cyc, stall_o, exp_stall); end
      if (ack_o) begin
        e = sb.pop_front(); acks++;
        checks++; if (cyc !== e.cyc)     begin errors++; $display("FAIL b2b_ack_cyc got %0d exp %0d", cyc, e.cyc); end
        checks++; if (data_o !== e.data) begin errors++; $display("FAIL b2b_data got %h exp %h", data_o, e.data); end
        checks++; if (err_o !== e.err)   begin errors++; $display("FAIL b2b_err got %b exp %b", err_o, e.err); end
        if (acks < n) present(acks); else cs = 0;
      end else scramble();
    end
    checks++; if (acks != n) begin errors++; $display("FAIL b2b_timeout acks %0d exp %0d", acks, n); sb.delete(); end
    cs = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    cs = 1; we = 1; addr = 32'h10; wdat = 32'h0000_1234;
    @(negedge clk);
    cs = 0; addr = 32'h0; wdat = 32'h0;
    @(negedge clk);
    rst = 1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got %b exp 0", stall_o); end
    checks++; if (ack_o !== 1'b0 || err_o !== 1'b0 || data_o !== '0) begin
      errors++; $display("FAIL mid_rst_outputs ack %b err %b data %h exp 0 0 0", ack_o, err_o, data_o);
    end
    @(negedge clk); @(negedge clk);
    rst = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack_o) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_rst_late_ack got %0d acks exp 0", seen); end
  endtask

  task automatic test_capture();
    int   acks = 0;
    int   n;
    exp_t e;
    rq_clear();
    rq_add(1'b1, 32'h0C, 32'h5A5A_5A5A);
    rq_add(1'b0, 32'h0C, 32'h0);
    rq_add(1'b0, 32'h10, 32'h0);
    n = rq_we.size();
    start_seq();
    for (int i = 0; i < 20 * n && acks < n; i++) begin
      @(negedge clk);
      if (ack_o) begin
        e = sb.pop_front(); acks++;
        checks++; if (cyc !== e.cyc)     begin errors++; $display("FAIL cap_ack_cyc got %0d exp %0d", cyc, e.cyc); end
        checks++; if (data_o !== e.data) begin errors++; $display("FAIL cap_data got %h exp %h", data_o, e.data); end
        checks++; if (err_o !== e.err)   begin errors++; $display("FAIL cap_err got %b exp %b", err_o, e.err); end
        if (acks < n) present(acks); else cs = 0;
      end else scramble();
    end
    checks++; if (acks != n) begin errors++; $display("FAIL cap_timeout acks %0d exp %0d", acks, n); sb.delete(); end
    cs = 0;
    @(negedge clk);
  endtask

  task automatic test_errors();
    int   acks = 0;
    int   n;
    exp_t e;
    rq_clear();
    rq_add(1'b1, 32'h00, 32'h1111_1111);
    rq_add(1'b0, 32'h06, 32'h0);
    rq_add(1'b1, 32'h80, 32'hFFFF_FFFF);
    rq_add(1'b0, 32'h00, 32'h0);
    n = rq_we.size();
    start_seq();
    for (int i = 0; i < 20 * n && acks < n; i++) begin
      @(negedge clk);
      if (ack_o) begin
        e = sb.pop_front(); acks++;
        checks++; if (cyc !== e.cyc)     begin errors++; $display("FAIL err_ack_cyc got %0d exp %0d", cyc, e.cyc); end
        checks++; if (data_o !== e.data) begin errors++; $display("FAIL err_data got %h exp %h", data_o, e.data); end
        checks++; if (err_o !== e.err)   begin errors++; $display("FAIL err_flag got %b exp %b", err_o, e.err); end
        if (acks < n) present(acks); else cs = 0;
      end else scramble();
    end
    checks++; if (acks != n) begin errors++; $display("FAIL err_timeout acks %0d exp %0d", acks, n); sb.delete(); end
    cs = 0;
    @(negedge clk);
  endtask

  task automatic test_min_latency();
    logic [W-1:0] ed;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cs1 = 1; we1 = (k == 0); addr1 = 32'h20; wdat1 = 32'h0BAD_F00D;
      sb1.push_back((k == 0) ? 32'h0 : 32'h0BAD_F00D);
      #1;
      checks++; if (stall1_o !== 1'b1) begin errors++; $display("FAIL lat1_stall_accept got %b exp 1", stall1_o); end
      @(negedge clk);
      cs1 = 0; addr1 = $urandom; wdat1 = $urandom;
      checks++; if (ack1_o !== 1'b0 || stall1_o !== 1'b1) begin
        errors++; $display("FAIL lat1_busy ack %b stall %b exp 0 1", ack1_o, stall1_o);
      end
      @(negedge clk);
      checks++; if (ack1_o !== 1'b1) begin errors++; $display("FAIL lat1_ack got %b exp 1", ack1_o); end
      checks++; if (stall1_o !== 1'b0 || err1_o !== 1'b0) begin
        errors++; $display("FAIL lat1_resp stall %b err %b exp 0 0", stall1_o, err1_o);
      end
      ed = sb1.pop_front();
      checks++; if (data1_o !== ed) begin errors++; $display("FAIL lat1_data got %h exp %h", data1_o, ed); end
      @(negedge clk);
      checks++; if (ack1_o !== 1'b0) begin errors++; $display("FAIL lat1_ack_width got %b exp 0", ack1_o); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_capture();
    test_errors();
    test_min_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
